// File: rtl/l2_port_arbiter.sv
// Shares one L2 memory port between the I-cache read, D-cache read and D-cache write channels.
// One transaction in flight; fixed priority write > data read > instruction, with an instruction starvation guard.
module l2_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int L2_BUS_WIDTH  = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ADDRESS_TO_L2_VALID_INS,
  output logic                     ADDRESS_TO_L2_READY_INS,
  input  logic [ADDRESS_WIDTH-3:0] ADDRESS_TO_L2_INS,
  output logic                     DATA_FROM_L2_VALID_INS,
  input  logic                     DATA_FROM_L2_READY_INS,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_INS,
  input  logic                     READ_ADDR_TO_L2_VALID_DATA,
  output logic                     READ_ADDR_TO_L2_READY_DATA,
  input  logic [ADDRESS_WIDTH-3:0] READ_ADDR_TO_L2_DATA,
  output logic                     DATA_FROM_L2_VALID_DATA,
  input  logic                     DATA_FROM_L2_READY_DATA,
  output logic [L2_BUS_WIDTH-1:0]  DATA_FROM_L2_DATA,
  input  logic                     WRITE_TO_L2_VALID_DATA,
  output logic                     WRITE_TO_L2_READY_DATA,
  input  logic [ADDRESS_WIDTH-3:0] WRITE_ADDR_TO_L2_DATA,
  input  logic [L2_BUS_WIDTH-1:0]  DATA_TO_L2_DATA,
  output logic                     WRITE_COMPLETE_DATA,
  output logic                     MEM_REQ_VALID,
  input  logic                     MEM_REQ_READY,
  output logic                     MEM_REQ_WRITE,
  output logic [ADDRESS_WIDTH-3:0] MEM_REQ_ADDR,
  output logic [L2_BUS_WIDTH-1:0]  MEM_REQ_WDATA,
  input  logic                     MEM_RESP_VALID,
  input  logic [L2_BUS_WIDTH-1:0]  MEM_RESP_DATA
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RESP, RESP, WR_DONE} state_t;

  state_t                   state_reg;
  logic [ADDRESS_WIDTH-3:0] addr_reg;
  logic [L2_BUS_WIDTH-1:0]  wdata_reg;
  logic [L2_BUS_WIDTH-1:0]  resp_reg;
  logic                     write_reg;
  logic                     owner_ins_reg;
  logic [CW-1:0]            starve_cnt_reg;

  logic is_idle;
  logic ins_force;
  logic grant_wr;
  logic grant_rd;
  logic grant_ins;
  logic resp_taken;

  // A saturated starvation counter lets a waiting instruction fetch jump ahead of data traffic.
  assign is_idle   = (state_reg == IDLE);
  assign ins_force = ADDRESS_TO_L2_VALID_INS && (starve_cnt_reg == STARVE_MAX);
  assign grant_wr  = is_idle && WRITE_TO_L2_VALID_DATA && !ins_force;
  assign grant_rd  = is_idle && READ_ADDR_TO_L2_VALID_DATA && !WRITE_TO_L2_VALID_DATA && !ins_force;
  assign grant_ins = is_idle && ADDRESS_TO_L2_VALID_INS &&
                     (ins_force || !(WRITE_TO_L2_VALID_DATA || READ_ADDR_TO_L2_VALID_DATA));

  assign ADDRESS_TO_L2_READY_INS    = grant_ins;
  assign READ_ADDR_TO_L2_READY_DATA = grant_rd;
  assign WRITE_TO_L2_READY_DATA     = grant_wr;

  assign MEM_REQ_VALID           = (state_reg == ISSUE);
  assign MEM_REQ_WRITE           = write_reg;
  assign MEM_REQ_ADDR            = addr_reg;
  assign MEM_REQ_WDATA           = wdata_reg;
  assign WRITE_COMPLETE_DATA     = (state_reg == WR_DONE);
  assign DATA_FROM_L2_VALID_INS  = (state_reg == RESP) && owner_ins_reg;
  assign DATA_FROM_L2_VALID_DATA = (state_reg == RESP) && !owner_ins_reg;
  assign DATA_FROM_L2_INS        = resp_reg;
  assign DATA_FROM_L2_DATA       = resp_reg;
  assign resp_taken = owner_ins_reg ? DATA_FROM_L2_READY_INS : DATA_FROM_L2_READY_DATA;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      resp_reg       <= '0;
      write_reg      <= 1'b0;
      owner_ins_reg  <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_wr || grant_rd || grant_ins) begin
            addr_reg      <= grant_wr ? WRITE_ADDR_TO_L2_DATA :
                             grant_rd ? READ_ADDR_TO_L2_DATA : ADDRESS_TO_L2_INS;
            wdata_reg     <= grant_wr ? DATA_TO_L2_DATA : '0;
            write_reg     <= grant_wr;
            owner_ins_reg <= grant_ins;
            if (grant_ins || !ADDRESS_TO_L2_VALID_INS)
              starve_cnt_reg <= '0;
            else if (starve_cnt_reg != STARVE_MAX)
              starve_cnt_reg <= starve_cnt_reg + 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (MEM_REQ_READY)
            state_reg <= write_reg ? WR_DONE : WAIT_RESP;
        end
        WAIT_RESP: begin
          if (MEM_RESP_VALID) begin
            resp_reg  <= MEM_RESP_DATA;
            state_reg <= RESP;
          end
        end
        RESP: begin
          if (resp_taken)
            state_reg <= IDLE;
        end
        WR_DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Randomized bench for l2_port_arbiter: three L1 agents and an L2 memory agent checked each cycle
// against a transaction-level model of arbitration, starvation and response routing.
module tb_l2_port_arbiter;

  localparam int AW    = 30;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ins_v = 1'b0, ins_rdy, dv_ins, dr_ins = 1'b0;
  logic [AW-1:0] ins_a = '0;
  logic [DW-1:0] d_ins, d_dat;
  logic          rd_v = 1'b0, rd_rdy, dv_dat, dr_dat = 1'b0;
  logic [AW-1:0] rd_a = '0;
  logic          wr_v = 1'b0, wr_rdy, wc;
  logic [AW-1:0] wr_a = '0;
  logic [DW-1:0] wr_d = '0;
  logic          mreq_v, mreq_rdy = 1'b0, mreq_w;
  logic [AW-1:0] mreq_a;
  logic [DW-1:0] mreq_d;
  logic          resp_v = 1'b0;
  logic [DW-1:0] resp_d = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Transaction-level model
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            starve = 0;
  bit            busy = 0, issued = 0, resp_got = 0, wr_pulse = 0, t_write = 0;
  int            owner = 0;            // 0 ins read, 1 data read, 2 write
  logic [AW-1:0] t_addr = '0;
  logic [DW-1:0] t_wdata = '0, t_rdata = '0;
  int            countdown = 0;
  bit            drop_ins = 0, drop_rd = 0, drop_wr = 0;
  bit            hot = 0;
  int            n_txn = 0;

  always #5 clk = ~clk;

  l2_port_arbiter #(.ADDRESS_WIDTH(AW + 2), .L2_BUS_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .CLK(clk), .RST(rst),
    .ADDRESS_TO_L2_VALID_INS(ins_v), .ADDRESS_TO_L2_READY_INS(ins_rdy), .ADDRESS_TO_L2_INS(ins_a),
    .DATA_FROM_L2_VALID_INS(dv_ins), .DATA_FROM_L2_READY_INS(dr_ins), .DATA_FROM_L2_INS(d_ins),
    .READ_ADDR_TO_L2_VALID_DATA(rd_v), .READ_ADDR_TO_L2_READY_DATA(rd_rdy), .READ_ADDR_TO_L2_DATA(rd_a),
    .DATA_FROM_L2_VALID_DATA(dv_dat), .DATA_FROM_L2_READY_DATA(dr_dat), .DATA_FROM_L2_DATA(d_dat),
    .WRITE_TO_L2_VALID_DATA(wr_v), .WRITE_TO_L2_READY_DATA(wr_rdy), .WRITE_ADDR_TO_L2_DATA(wr_a),
    .DATA_TO_L2_DATA(wr_d), .WRITE_COMPLETE_DATA(wc),
    .MEM_REQ_VALID(mreq_v), .MEM_REQ_READY(mreq_rdy), .MEM_REQ_WRITE(mreq_w),
    .MEM_REQ_ADDR(mreq_a), .MEM_REQ_WDATA(mreq_d),
    .MEM_RESP_VALID(resp_v), .MEM_RESP_DATA(resp_d)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_mem(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return DW'(a) ^ 32'hC0DE_0000;
  endfunction

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ctl"}, 64'({ins_rdy, rd_rdy, wr_rdy, dv_ins, dv_dat, wc, mreq_v, mreq_w}), 64'd0);
    check_eq({tag, "_addr"}, 64'(mreq_a), 64'd0);
    check_eq({tag, "_wdata"}, 64'(mreq_d), 64'd0);
    check_eq({tag, "_rdata"}, {d_ins, d_dat}, 64'd0);
  endtask

  task automatic drive();
    int rate;
    rate = hot ? 4 : 2;
    if (drop_ins) begin ins_v = 1'b0; drop_ins = 0; end
    if (drop_rd)  begin rd_v  = 1'b0; drop_rd  = 0; end
    if (drop_wr)  begin wr_v  = 1'b0; drop_wr  = 0; end
    if (!ins_v && $urandom_range(3) < 2) begin ins_v = 1'b1; ins_a = AW'($urandom_range(15)); end
    if (!rd_v && $urandom_range(3) < rate) begin rd_v = 1'b1; rd_a = AW'($urandom_range(15)); end
    if (!wr_v && $urandom_range(7) < rate) begin
      wr_v = 1'b1; wr_a = AW'($urandom_range(15)); wr_d = $urandom;
    end
    dr_ins   = 1'($urandom_range(1));
    dr_dat   = 1'($urandom_range(1));
    mreq_rdy = ($urandom_range(2) != 0);
    resp_v   = 1'b0;
    if (busy && issued && !t_write && !resp_got) begin
      if (countdown == 0) begin resp_v = 1'b1; resp_d = t_rdata; end
      else countdown--;
    end else if ($urandom_range(7) == 0) begin
      resp_v = 1'b1; resp_d = $urandom;    // stray response, must be ignored
    end
  endtask

  task automatic step();
    int win;
    logic [2:0] exp_rdy;
    @(negedge clk);
    drive();
    #1;
    win = -1;
    if (!busy) begin
      if (ins_v && starve == LIMIT) win = 0;
      else if (wr_v) win = 2;
      else if (rd_v) win = 1;
      else if (ins_v) win = 0;
    end
    exp_rdy = 3'b000;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check_eq("ready_vec", 64'({wr_rdy, rd_rdy, ins_rdy}), 64'(exp_rdy));
    check_eq("mem_req_valid", 64'(mreq_v), 64'(busy && !issued));
    if (busy && !issued) begin
      check_eq("mem_req_addr", 64'(mreq_a), 64'(t_addr));
      check_eq("mem_req_write", 64'(mreq_w), 64'(t_write));
      if (t_write) check_eq("mem_req_wdata", 64'(mreq_d), 64'(t_wdata));
    end
    check_eq("write_complete", 64'(wc), 64'(busy && wr_pulse));
    check_eq("data_valid_ins", 64'(dv_ins), 64'(busy && resp_got && owner == 0));
    check_eq("data_valid_dat", 64'(dv_dat), 64'(busy && resp_got && owner == 1));
    if (busy && resp_got) check_eq("resp_data", 64'(owner == 0 ? d_ins : d_dat), 64'(t_rdata));

    if (win >= 0) begin
      if (win == 0) starve = 0;
      else if (ins_v) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
      else starve = 0;
      busy = 1; owner = win; issued = 0; resp_got = 0; wr_pulse = 0;
      t_write = (win == 2);
      t_wdata = '0;
      case (win)
        0: begin t_addr = ins_a; drop_ins = 1; end
        1: begin t_addr = rd_a;  drop_rd  = 1; end
        default: begin t_addr = wr_a; t_wdata = wr_d; drop_wr = 1; end
      endcase
    end else if (busy && !issued) begin
      if (mreq_rdy) begin
        issued = 1;
        if (t_write) begin mem[t_addr] = t_wdata; wr_pulse = 1; end
        else begin t_rdata = rd_mem(t_addr); countdown = $urandom_range(2); end
      end
    end else if (busy && wr_pulse) begin
      busy = 0; n_txn++;
      $display("txn %0d: write addr=%h data=%h", n_txn, t_addr, t_wdata);
    end else if (busy && issued && !resp_got) begin
      if (resp_v) resp_got = 1;
    end else if (busy && resp_got) begin
      if ((owner == 0 && dr_ins) || (owner == 1 && dr_dat)) begin
        busy = 0; n_txn++;
        $display("txn %0d: %s read addr=%h data=%h", n_txn, owner == 0 ? "ins" : "data", t_addr, t_rdata);
      end
    end
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    repeat (1500) step();
    hot = 1;
    repeat (1500) step();
    hot = 0;

    // Drive until a read is waiting on L2, then reset mid-transaction.
    guard = 0;
    while (!(busy && issued && !t_write && !resp_got) && guard < 2000) begin
      step();
      guard++;
    end
    check_eq("reach_wait_resp", 64'(guard < 2000), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    ins_v = 1'b0; rd_v = 1'b0; wr_v = 1'b0; resp_v = 1'b0;
    drop_ins = 0; drop_rd = 0; drop_wr = 0;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    resp_v = 1'b1; resp_d = 32'h1234_5678;
    #1;
    check_all_zero("late_resp");
    @(negedge clk);
    resp_v = 1'b0;
    #1;
    check_all_zero("after_late_resp");
    busy = 0; issued = 0; resp_got = 0; wr_pulse = 0; starve = 0;

    repeat (1000) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/l2_port_arbiter.md
# l2_port_arbiter

Shares the single L2 memory port between the three L1 channels of `RISCV_PROCESSOR`: instruction-cache line read, data-cache read and data-cache write. It accepts one request at a time, issues it to the L2 port, and returns read data to the requesting L1 cache or pulses write completion. It sits between the processor's `*_TO_L2_*` / `*_FROM_L2_*` buses and the L2 model or memory. Arbitration is fixed-priority with a starvation guard for instruction fetch.

## Interface

- `ADDRESS_WIDTH`, 32, byte address width; the L2 word address is `ADDRESS_WIDTH-2` bits.
- `L2_BUS_WIDTH`, 32, L2 data bus width.
- `STARVE_LIMIT`, 4, consecutive data grants allowed while an instruction request waits (≥1).

Ports:

- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `ADDRESS_TO_L2_VALID_INS` in 1 / `ADDRESS_TO_L2_READY_INS` out 1 / `ADDRESS_TO_L2_INS` in `ADDRESS_WIDTH-2`  I-cache read request.
- `DATA_FROM_L2_VALID_INS` out 1 / `DATA_FROM_L2_READY_INS` in 1 / `DATA_FROM_L2_INS` out `L2_BUS_WIDTH`  I-cache read data.
- `READ_ADDR_TO_L2_VALID_DATA` in 1 / `READ_ADDR_TO_L2_READY_DATA` out 1 / `READ_ADDR_TO_L2_DATA` in `ADDRESS_WIDTH-2`  D-cache read request.
- `DATA_FROM_L2_VALID_DATA` out 1 / `DATA_FROM_L2_READY_DATA` in 1 / `DATA_FROM_L2_DATA` out `L2_BUS_WIDTH`  D-cache read data.
- `WRITE_TO_L2_VALID_DATA` in 1 / `WRITE_TO_L2_READY_DATA` out 1 / `WRITE_ADDR_TO_L2_DATA` in `ADDRESS_WIDTH-2` / `DATA_TO_L2_DATA` in `L2_BUS_WIDTH`  D-cache write request.
- `WRITE_COMPLETE_DATA`  out  1  one-cycle pulse when the write is accepted by L2.
- `MEM_REQ_VALID` out 1 / `MEM_REQ_READY` in 1 / `MEM_REQ_WRITE` out 1 / `MEM_REQ_ADDR` out `ADDRESS_WIDTH-2` / `MEM_REQ_WDATA` out `L2_BUS_WIDTH`  L2 request.
- `MEM_RESP_VALID` in 1 / `MEM_RESP_DATA` in `L2_BUS_WIDTH`  L2 read response (no backpressure).

## Operation

- FSM states: IDLE, ISSUE, WAIT_RESP, RESP, WR_DONE.
- IDLE: pick a winner among the valid requests. Priority is write > data read > instruction read.
  - Override: if the instruction request is valid and `starve_cnt == STARVE_LIMIT`, the instruction request wins.
  - The winner's `*_READY` is asserted combinationally in IDLE only; all other READYs are 0.
  - On valid&ready, latch the address, the write data and the request type, then go to ISSUE.
- ISSUE: drive `MEM_REQ_VALID=1` with the latched fields, held stable until `MEM_REQ_READY`.
  - On handshake, a read goes to WAIT_RESP and a write goes to WR_DONE.
- WAIT_RESP: on `MEM_RESP_VALID`, capture `MEM_RESP_DATA` into the response register and go to RESP.
- RESP: assert the owner's `DATA_FROM_L2_VALID_*` with the registered data, held stable until the matching `DATA_FROM_L2_READY_*`. Then return to IDLE.
- WR_DONE: `WRITE_COMPLETE_DATA=1` for exactly one cycle, then IDLE.
- `starve_cnt` (clog2(`STARVE_LIMIT`+1) bits), updated at each IDLE grant:
  - Data grant while the instruction request is valid: increment, saturating at `STARVE_LIMIT`.
  - Instruction grant: clear.
  - Instruction request not valid at grant time: clear.
- Only one transaction is outstanding at a time. Requests arriving outside IDLE wait; the L1 holds VALID.
- `MEM_RESP_VALID` outside WAIT_RESP is ignored.
- Reset (any time, including mid-transaction):
  - State returns to IDLE, `starve_cnt`=0, and the latched registers and response register clear to 0.
  - Every output reads 0, except IDLE-combinational READYs once requests are present after reset release.
  - The abandoned transaction is dropped. A late `MEM_RESP_VALID` after reset is ignored.

## Timing

- Request handshake in cycle 0 (IDLE). `MEM_REQ_VALID` rises in cycle 1.
- Minimum read latency, with `MEM_REQ_READY` already high and the response the following cycle:
  - cycle 1 ISSUE, cycle 2 WAIT_RESP captures the response, cycle 3 `DATA_FROM_L2_VALID_*`=1.
  - Earliest next request handshake is cycle 4 if the L1 READY is high in cycle 3.
- Minimum write: cycle 1 ISSUE handshake, cycle 2 `WRITE_COMPLETE_DATA` pulse, cycle 3 IDLE.
- Simultaneous requests in IDLE: exactly one READY is high; the losers' READY stays low.
- Valid held low by L1 in IDLE: no state change.

## Test plan

- Single instruction read at addr 0x5. L2 returns 0x00500093 one cycle after request -> `DATA_FROM_L2_INS`=0x00500093, valid 3 cycles after handshake, held until READY.
- Write 0xDEADBEEF to 0x10, then data read of 0x10 with L2 backing store -> `MEM_REQ_WRITE`=1 then 0. `WRITE_COMPLETE_DATA` is a 1-cycle pulse. Read returns 0xDEADBEEF.
- All three channels valid in the same cycle -> grant order write, data read, instruction. Only one READY high per IDLE cycle.
- Data read held continuously valid with `STARVE_LIMIT`=4 while an instruction read waits -> the instruction is granted after exactly 4 data grants, then the counter is 0.
- `MEM_REQ_READY` low for 5 cycles in ISSUE -> `MEM_REQ_*` fields stable and no other READY asserted. `DATA_FROM_L2_READY_DATA` low for 3 cycles in RESP -> data held.
- `RST` asserted in WAIT_RESP, then `MEM_RESP_VALID` pulse after release -> all outputs 0, no `DATA_FROM_L2_VALID_*`, next request serviced normally.
